// File: rtl/uart_char_source.sv
// UART receiver feeding a small show-ahead FIFO that presents page chars on the
// parser's pausable char stream; the end-of-transmission byte closes the page.
module uart_char_source #(
  parameter int         CHAR_W          = 8,
  parameter int         CLKS_PER_BIT    = 434,
  parameter int         FIFO_DEPTH_LOG2 = 4,
  parameter logic [7:0] EOT_CHAR        = 8'h04
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              uart_rx,
  input  logic              pause,
  output logic [CHAR_W-1:0] char_out,
  output logic              char_valid,
  output logic              has_finished,
  output logic              frame_err,
  output logic              overflow
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

  rx_state_e         state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic              rx_s;
  logic              armed_q, armed_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              push_req_q, push_req_d;
  logic              frame_err_q, frame_err_d;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CHAR_W-1:0] char_q, char_d;
  logic              char_valid_q, char_valid_d;
  logic              eot_seen_q, eot_seen_d;
  logic              overflow_q, overflow_d;
  logic              finished_q, finished_d;
  logic              consume, fifo_full, byte_ok, do_push;

  logic [CHAR_W-1:0] mem [DEPTH];

  assign rx_s = sync_q[1];

  // Receiver: counters run down to zero, so each sample lands mid-bit.
  always_comb begin
    sync_d      = {sync_q[0], uart_rx};
    armed_d     = armed_q | rx_s;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_req_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (armed_q && !rx_s) begin
          state_d = RX_START;
          cnt_d   = HALF_LAST;
        end
      end
      RX_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_s) begin
          state_d   = RX_DATA;
          cnt_d     = BIT_LAST;
          bit_idx_d = '0;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = BIT_LAST;
          if (bit_idx_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_s) begin
          push_req_d = 1'b1;
          state_d    = RX_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = RX_WAIT_IDLE;
        end
      end
      RX_WAIT_IDLE: begin
        if (rx_s) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // The head is re-read every cycle from the post-pop pointer against the
  // pre-push write pointer, which gives the one-cycle show-ahead latency.
  always_comb begin
    consume      = char_valid_q && !pause;
    fifo_full    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
    byte_ok      = push_req_q && (shift_q != EOT_CHAR) && !eot_seen_q;
    do_push      = byte_ok && (!fifo_full || consume);
    eot_seen_d   = eot_seen_q || (push_req_q && (shift_q == EOT_CHAR));
    overflow_d   = overflow_q || (byte_ok && fifo_full && !consume);
    wr_ptr_d     = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d     = rd_ptr_q + PTR_W'(consume);
    char_valid_d = (wr_ptr_q != rd_ptr_d);
    char_d       = char_valid_d ? mem[rd_ptr_d[PTR_W-2:0]] : '0;
    finished_d   = finished_q ||
                   (eot_seen_q && (wr_ptr_q == rd_ptr_q) && !char_valid_q);
  end

  always_ff @(posedge CLOCK_50) begin
    if (do_push) begin
      mem[wr_ptr_q[PTR_W-2:0]] <= CHAR_W'(shift_q);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= RX_IDLE;
      sync_q       <= '0;
      armed_q      <= 1'b0;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      push_req_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      char_q       <= '0;
      char_valid_q <= 1'b0;
      eot_seen_q   <= 1'b0;
      overflow_q   <= 1'b0;
      finished_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      push_req_q   <= push_req_d;
      frame_err_q  <= frame_err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      char_q       <= char_d;
      char_valid_q <= char_valid_d;
      eot_seen_q   <= eot_seen_d;
      overflow_q   <= overflow_d;
      finished_q   <= finished_d;
    end
  end

  assign char_out     = char_q;
  assign char_valid   = char_valid_q;
  assign has_finished = finished_q;
  assign frame_err    = frame_err_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_uart_char_source.sv
// Randomised scoreboard bench for uart_char_source: serial frames in, expected
// chars queued at issue time and popped by a monitor as the parser consumes them.
module tb_uart_char_source;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       uart_rx = 1'b1;
  logic       pause = 1'b0;
  logic [7:0] char_out;
  logic       char_valid, has_finished, frame_err, overflow;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  bit         m_eot = 1'b0;
  bit         m_ovf = 1'b0;
  int         m_fe = 0;
  int         fe_seen = 0;
  bit         rand_pause = 1'b0;

  always #5 clk = ~clk;

  uart_char_source #(
    .CHAR_W(8),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH_LOG2(2),
    .EOT_CHAR(8'h04)
  ) dut (
    .CLOCK_50(clk),
    .resetn(resetn),
    .uart_rx(uart_rx),
    .pause(pause),
    .char_out(char_out),
    .char_valid(char_valid),
    .has_finished(has_finished),
    .frame_err(frame_err),
    .overflow(overflow)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good_stop);
    logic [9:0] fr;
    fr = {good_stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (CPB) begin
        @(posedge clk); #1;
        if (rand_pause) pause = 1'($urandom_range(0, 1));
      end
    end
    uart_rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
  endtask

  // Reference model: decide the fate of the byte from the page rules alone.
  task automatic issue_byte(input logic [7:0] b, input bit good_stop);
    if (!good_stop) m_fe++;
    else if (b == 8'h04) m_eot = 1'b1;
    else if (m_eot) begin end
    else if (exp_q.size() >= DEPTH) m_ovf = 1'b1;
    else exp_q.push_back(b);
    $display("sent byte %02h stop=%0d queued=%0d", b, good_stop, exp_q.size());
    send_frame(b, good_stop);
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("frame_err_count", 32'(fe_seen), 32'(m_fe));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d chars pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, "_finished"}, 32'(has_finished), 32'(m_eot && exp_q.size() == 0));
    check({tag, "_frame_errs"}, 32'(fe_seen), 32'(m_fe));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_char"}, 32'(char_out), 32'h0);
    check({tag, "_valid"}, 32'(char_valid), 32'h0);
    check({tag, "_finished"}, 32'(has_finished), 32'h0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    check({tag, "_overflow"}, 32'(overflow), 32'h0);
  endtask

  initial begin
    logic [7:0] rb;
    logic [7:0] part;

    #2 resetn = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    fork
      forever begin
        @(negedge clk);
        if (resetn) begin
          if (frame_err) fe_seen++;
          checks++;
          if (char_valid) begin
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL char_unexpected: got %02h valid, required no char", char_out);
            end else if (char_out !== exp_q[0]) begin
              errors++;
              $display("FAIL char_value: got %02h, required %02h", char_out, exp_q[0]);
              if (!pause) void'(exp_q.pop_front());
            end else if (!pause) begin
              $display("consumed char %02h", char_out);
              void'(exp_q.pop_front());
            end
          end else if (char_out !== 8'h00) begin
            errors++;
            $display("FAIL char_idle: got %02h, required 00", char_out);
          end
        end
      end
    join_none

    // 1: two chars streamed with no back-pressure
    issue_byte(8'h48, 1'b1);
    issue_byte(8'h69, 1'b1);
    wait_drain();
    check_status("t1");

    // 2: paused head must hold until released
    pause = 1'b1;
    issue_byte(8'h3C, 1'b1);
    issue_byte(8'h62, 1'b1);
    repeat (10) @(posedge clk);
    #1 pause = 1'b0;
    wait_drain();
    check_status("t2");

    // 3: fifth byte into a full paused FIFO is dropped
    pause = 1'b1;
    for (int i = 0; i < 5; i++) issue_byte(8'h41 + 8'(i), 1'b1);
    pause = 1'b0;
    wait_drain();
    check_status("t3");

    // 4: bad stop bit, then a clean byte
    issue_byte(8'h48, 1'b0);
    issue_byte(8'h49, 1'b1);
    wait_drain();
    check_status("t4");

    // 5: end of transmission
    issue_byte(8'h61, 1'b1);
    issue_byte(8'h04, 1'b1);
    issue_byte(8'h62, 1'b1);
    wait_drain();
    check_status("t5");

    // 6: reset in the middle of bit 3 with two chars buffered
    pause = 1'b1;
    issue_byte(8'h11, 1'b1);
    issue_byte(8'h22, 1'b1);
    part = 8'h5A;
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      #1 uart_rx = part[i];
      repeat (CPB) @(posedge clk);
    end
    #1 uart_rx = part[3];
    repeat (2) @(posedge clk);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("midbyte_reset");
    exp_q.delete();
    m_eot = 1'b0;
    m_ovf = 1'b0;
    uart_rx = 1'b1;
    pause = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    issue_byte(8'h55, 1'b1);
    wait_drain();
    check_status("t6");

    // Random traffic with random back-pressure
    rand_pause = 1'b1;
    for (int i = 0; i < 24; i++) begin
      rb = 8'($urandom_range(0, 255));
      if (rb == 8'h04) rb = 8'hA4;
      issue_byte(rb, $urandom_range(0, 9) != 0);
    end
    rand_pause = 1'b0;
    #1 pause = 1'b0;
    wait_drain();
    check_status("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
